// File: rtl/fixed_div.sv
// Iterative signed fixed-point divider: restoring shift-subtract, one quotient bit per clock.
// Works on magnitudes of (a << FRAC) and b; sign, saturation and divide-by-zero are resolved in DONE.
module fixed_div #(
    parameter int BITS      = 8,
    parameter int FRAC      = 4,
    parameter     PRECISION = "FIXED_4_4"
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    output logic            out_valid,
    output logic [BITS-1:0] c,
    output logic            ovf,
    output logic            dz
);

    localparam int N  = BITS + FRAC;
    localparam int CW = $clog2(N + 1);

    localparam logic [BITS-1:0] PosSat    = {1'b0, {(BITS-1){1'b1}}};
    localparam logic [BITS-1:0] NegSat    = {1'b1, {(BITS-1){1'b0}}};
    localparam logic [N-1:0]    MaxPosMag = N'(PosSat);
    localparam logic [N-1:0]    MaxNegMag = N'(NegSat);

    // PRECISION is a descriptive label only; the arithmetic is governed by BITS/FRAC.
    if (PRECISION == "") begin : g_unlabelled
    end

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state_q;
    logic [N-1:0]    dvd_q;
    logic [BITS-1:0] rem_q;
    logic [BITS-1:0] dvsr_q;
    logic [CW-1:0]   cnt_q;
    logic            neg_q;
    logic            nega_q;
    logic            zero_q;
    logic            valid_q;
    logic [BITS-1:0] c_q;
    logic            ovf_q;
    logic            dz_q;

    logic [BITS-1:0] a_mag;
    logic [BITS-1:0] b_mag;
    logic [BITS:0]   rem_sh;
    logic            fits;
    logic [BITS-1:0] rem_d;
    logic [N-1:0]    dvd_d;
    logic [BITS-1:0] res_c;
    logic            res_ovf;

    assign a_mag = a[BITS-1] ? (~a + 1'b1) : a;
    assign b_mag = b[BITS-1] ? (~b + 1'b1) : b;

    // The dividend register doubles as the quotient register: quotient bits enter at the LSB.
    assign rem_sh = {rem_q, dvd_q[N-1]};
    assign fits   = (rem_sh >= {1'b0, dvsr_q});
    assign rem_d  = BITS'(fits ? (rem_sh - {1'b0, dvsr_q}) : rem_sh);
    assign dvd_d  = {dvd_q[N-2:0], fits};

    // Apply sign and clamp; the negative range reaches one step further than the positive range.
    always_comb begin
        res_c   = '0;
        res_ovf = 1'b0;
        if (zero_q) begin
            res_c   = nega_q ? NegSat : PosSat;
            res_ovf = 1'b1;
        end else if (!neg_q) begin
            if (dvd_q > MaxPosMag) begin
                res_c   = PosSat;
                res_ovf = 1'b1;
            end else begin
                res_c = dvd_q[BITS-1:0];
            end
        end else begin
            if (dvd_q > MaxNegMag) begin
                res_c   = NegSat;
                res_ovf = 1'b1;
            end else begin
                res_c = ~dvd_q[BITS-1:0] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            rem_q   <= '0;
            dvsr_q  <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            nega_q  <= 1'b0;
            zero_q  <= 1'b0;
            valid_q <= 1'b0;
            c_q     <= '0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        dvd_q   <= {a_mag, {FRAC{1'b0}}};
                        rem_q   <= '0;
                        dvsr_q  <= b_mag;
                        neg_q   <= a[BITS-1] ^ b[BITS-1];
                        nega_q  <= a[BITS-1];
                        zero_q  <= (b == '0);
                        cnt_q   <= CW'(N);
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    dvd_q <= dvd_d;
                    rem_q <= rem_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    valid_q <= 1'b1;
                    c_q     <= res_c;
                    ovf_q   <= res_ovf;
                    dz_q    <= zero_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = valid_q;
    assign c         = c_q;
    assign ovf       = ovf_q;
    assign dz        = dz_q;

endmodule
